// File: rtl/sd_sched.sv
// sd_sched: round-robin scheduler of four disk units onto one storage-device port.
// Optional watchdog abort enabled by defining SDSCHED_TIMEOUT_EN.
module sd_sched #(
    parameter int BLOCK_WORDS    = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:3] req,
    input  logic [0:3] req_write,
    output logic [0:3] grant,
    output logic [0:3] done,
    output logic       error,
    output logic       busy,
    output logic [1:0] sd_select,
    input  logic       command_ready,
    output logic       read_cmd,
    output logic       write_cmd,
    input  logic       read_data_enable,
    input  logic       write_data_enable
);
    typedef enum logic [2:0] {IDLE, SELECT, WAIT_RDY, XFER, DONE} state_t;
    localparam int CW = $clog2(BLOCK_WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

    state_t        r_state, w_state;
    logic [1:0]    r_ptr, w_ptr, w_sel, w_win, w_idx;
    logic          r_dir, w_dir, w_any, w_busy, w_rd, w_wr, w_err, w_strobe, w_to;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [0:3]    w_grant, w_done;

    assign w_strobe = r_dir ? write_data_enable : read_data_enable;

`ifdef SDSCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wd, w_wd;
    assign w_to = ((r_state == WAIT_RDY && !command_ready) || (r_state == XFER && !w_strobe))
                  && r_wd == TW'(TIMEOUT_CYCLES - 1);
    assign w_wd = (r_state == SELECT || (r_state == XFER && w_strobe)) ? '0 :
                  (r_state == WAIT_RDY || r_state == XFER) ? r_wd + 1'b1 : r_wd;
    always_ff @(posedge clk) begin
        if (reset) r_wd <= '0;
        else       r_wd <= w_wd;
    end
`else
    assign w_to = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // Descending scan so the unit nearest the pointer is assigned last and wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_sel   = sd_select;
        w_dir   = r_dir;
        w_cnt   = r_cnt;
        w_grant = grant;
        w_busy  = busy;
        w_done  = '0;
        w_err   = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_state        = SELECT;
                w_sel          = w_win;
                w_dir          = req_write[w_win];
                w_grant        = '0;
                w_grant[w_win] = 1'b1;
                w_busy         = 1'b1;
            end
            SELECT: w_state = WAIT_RDY;
            WAIT_RDY: if (command_ready) begin
                w_rd    = ~r_dir;
                w_wr    = r_dir;
                w_cnt   = '0;
                w_state = XFER;
            end
            XFER: if (w_strobe) begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state           = DONE;
                    w_done[sd_select] = 1'b1;
                    w_grant           = '0;
                    w_busy            = 1'b0;
                end
            end
            DONE: begin
                w_ptr   = sd_select + 2'd1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (w_to) begin
            w_state           = DONE;
            w_done[sd_select] = 1'b1;
            w_grant           = '0;
            w_busy            = 1'b0;
            w_err             = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            sd_select <= '0;
            grant     <= '0;
            done      <= '0;
            error     <= 1'b0;
            busy      <= 1'b0;
            read_cmd  <= 1'b0;
            write_cmd <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_dir     <= w_dir;
            r_cnt     <= w_cnt;
            sd_select <= w_sel;
            grant     <= w_grant;
            done      <= w_done;
            error     <= w_err;
            busy      <= w_busy;
            read_cmd  <= w_rd;
            write_cmd <= w_wr;
        end
    end
endmodule

// File: tb/tb_sd_sched.sv
// tb_sd_sched: randomized self-checking bench for sd_sched against a transaction-level model.
module tb_sd_sched;
    localparam int BW = 4;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset, command_ready, read_cmd, write_cmd, rde, wde, error, busy;
    logic [0:3] req, req_write, grant, done;
    logic [1:0] sd_select;
    int         checks = 0, errors = 0, m_ptr = 0;

    typedef struct {
        int         u;
        int         lat_cmd;
        int         ncmd;
        bit         cmd_ok;
        int         done_gap;
        int         done_from_g;
        logic [0:3] done_v;
        bit         done_ok;
        bit         once;
        bit         err;
        bit         stable;
    } res_t;

    always #5 clk = ~clk;

    sd_sched #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write), .grant(grant),
        .done(done), .error(error), .busy(busy), .sd_select(sd_select),
        .command_ready(command_ready), .read_cmd(read_cmd), .write_cmd(write_cmd),
        .read_data_enable(rde), .write_data_enable(wde)
    );

    function automatic logic [0:3] oh(input int u);
        logic [0:3] v;
        v = '0;
        v[u] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [0:3] rq, input int p);
        for (int k = 0; k < 4; k++) if (rq[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; req = '0; req_write = '0; command_ready = 1'b0; rde = 1'b0; wde = 1'b0;
        tick; tick;
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one whole grant: ready after d cycles, random matching strobes after the command,
    // optional noise on the ignored strobes, and records what the DUT did.
    task automatic run_one(input int d, input bit noise, input bit nostrobe,
                           input logic [0:3] rq_after, input int budget, output res_t r);
        int g, c4, sent;
        bit dirx, s, m, o;
        g = -1; c4 = -1; sent = 0; dirx = 1'b0;
        r.u = -1; r.lat_cmd = -1; r.ncmd = 0; r.cmd_ok = 0; r.done_gap = -1; r.done_from_g = -1;
        r.done_v = '0; r.done_ok = 0; r.once = 0; r.err = 0; r.stable = 1;
        for (int c = 0; c < budget; c++) begin
            tick;
            if (r.u < 0 && grant != 0) begin
                for (int k = 0; k < 4; k++) if (grant[k]) r.u = k;
                dirx = req_write[r.u];
                g = c;
            end
            if (read_cmd || write_cmd) begin
                r.ncmd++;
                if (r.lat_cmd < 0) begin
                    r.lat_cmd = c - g;
                    r.cmd_ok = (write_cmd == dirx) && (read_cmd == !dirx);
                end
            end
            if (r.u >= 0 && done != 0) begin
                r.done_v = done;
                r.done_ok = done == oh(r.u) && grant == 0 && busy == 0 && sent == BW
                            && sd_select == 2'(r.u);
                r.err = error;
                r.done_gap = c4 >= 0 ? c - c4 : -1;
                r.done_from_g = c - g;
                rde = 1'b0; wde = 1'b0;
                tick;
                r.once = done == 0 && error == 0;
                return;
            end
            if (r.u >= 0 && (grant != oh(r.u) || sd_select != 2'(r.u) || busy !== 1'b1)) r.stable = 0;
            if (r.u >= 0) begin
                req = rq_after;
                command_ready = (c - g >= d);
            end
            s = 1'b0;
            if (r.lat_cmd >= 0 && !nostrobe && sent < BW) s = 1'($urandom_range(0, 1));
            if (s) begin
                sent++;
                if (sent == BW) c4 = c;
            end
            m = s | (noise && r.lat_cmd < 0 && 1'($urandom_range(0, 1)));
            o = noise && 1'($urandom_range(0, 1));
            wde = dirx ? m : o;
            rde = dirx ? o : m;
        end
        rde = 1'b0; wde = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'hF; req_write = 4'hF; command_ready = 1'b1; rde = 1'b1; wde = 1'b1;
        tick; tick; tick;
        checks++;
        if ({grant, done, error, busy, sd_select, read_cmd, write_cmd} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b done=%b err=%b busy=%b sel=%0d rc=%b wc=%b want all 0",
                     grant, done, error, busy, sd_select, read_cmd, write_cmd);
        end
        do_reset;
        tick;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got grant=%b busy=%b want 0000 0", grant, busy);
        end
    endtask

    task automatic test_single_read;
        res_t r;
        do_reset;
        req = oh(2); req_write = '0;
        run_one(0, 0, 0, '0, 100, r);
        checks++;
        if (r.u != 2 || !r.stable) begin
            errors++; $display("FAIL t1_grant got unit %0d stable %0d want unit 2 stable 1", r.u, r.stable);
        end
        checks++;
        if (r.lat_cmd != 2 || r.ncmd != 1 || !r.cmd_ok) begin
            errors++; $display("FAIL t1_cmd got lat %0d n %0d ok %0d want 2 1 1", r.lat_cmd, r.ncmd, r.cmd_ok);
        end
        checks++;
        if (!r.done_ok || r.done_gap != 1 || !r.once || r.err) begin
            errors++; $display("FAIL t1_done got ok %0d gap %0d once %0d err %0d want 1 1 1 0",
                               r.done_ok, r.done_gap, r.once, r.err);
        end
        m_ptr = 3;
        req = 4'hF;
        run_one(0, 0, 0, '0, 100, r);
        checks++;
        if (r.u != pick(4'hF, m_ptr)) begin
            errors++; $display("FAIL t1_pointer got unit %0d want %0d", r.u, pick(4'hF, m_ptr));
        end
    endtask

    task automatic test_round_robin;
        res_t r;
        do_reset;
        req = 4'hF; req_write = 4'($urandom_range(0, 15));
        for (int i = 0; i < 5; i++) begin
            run_one(0, 0, 0, 4'hF, 100, r);
            checks++;
            if (r.u != pick(4'hF, m_ptr) || !r.done_ok || !r.once || r.ncmd != 1 || !r.cmd_ok) begin
                errors++; $display("FAIL rr_%0d got unit %0d done %0d once %0d ncmd %0d want unit %0d done 1 once 1 ncmd 1",
                                   i, r.u, r.done_ok, r.once, r.ncmd, pick(4'hF, m_ptr));
            end
            m_ptr = (r.u + 1) % 4;
        end
    endtask

    task automatic test_write_wait;
        res_t r;
        do_reset;
        req = oh(1); req_write = oh(1);
        run_one(10, 1, 0, '0, 200, r);
        checks++;
        if (r.u != 1 || r.lat_cmd != 11 || !r.cmd_ok || r.ncmd != 1) begin
            errors++; $display("FAIL t3_cmd got unit %0d lat %0d ok %0d n %0d want 1 11 1 1",
                               r.u, r.lat_cmd, r.cmd_ok, r.ncmd);
        end
        checks++;
        if (!r.done_ok || r.done_gap != 1 || !r.stable) begin
            errors++; $display("FAIL t3_done got ok %0d gap %0d stable %0d want 1 1 1", r.done_ok, r.done_gap, r.stable);
        end
    endtask

    task automatic test_reset_mid;
        res_t r;
        do_reset;
        req = oh(1); req_write = '0; command_ready = 1'b1;
        tick;
        req = '0;
        tick; tick;
        rde = 1'b1;
        tick; tick;
        rde = 1'b0; reset = 1'b1;
        tick;
        checks++;
        if ({grant, done, error, busy, sd_select, read_cmd, write_cmd} !== 16'h0) begin
            errors++;
            $display("FAIL t4_reset got grant=%b done=%b err=%b busy=%b sel=%0d rc=%b wc=%b want all 0",
                     grant, done, error, busy, sd_select, read_cmd, write_cmd);
        end
        reset = 1'b0; m_ptr = 0;
        req = oh(1);
        run_one(0, 0, 0, '0, 100, r);
        checks++;
        if (r.u != 1 || !r.done_ok || r.done_gap != 1) begin
            errors++; $display("FAIL t4_restart got unit %0d ok %0d gap %0d want 1 1 1", r.u, r.done_ok, r.done_gap);
        end
    endtask

    task automatic test_req_change;
        res_t r;
        do_reset;
        req = oh(0); req_write = 4'($urandom_range(0, 15));
        run_one(1, 0, 0, oh(3), 100, r);
        checks++;
        if (r.u != 0 || !r.done_ok || !r.cmd_ok) begin
            errors++; $display("FAIL t5_first got unit %0d ok %0d cmd %0d want 0 1 1", r.u, r.done_ok, r.cmd_ok);
        end
        m_ptr = 1;
        run_one(0, 0, 0, oh(3), 100, r);
        checks++;
        if (r.u != pick(oh(3), m_ptr) || !r.done_ok) begin
            errors++; $display("FAIL t5_second got unit %0d ok %0d want %0d 1", r.u, r.done_ok, pick(oh(3), m_ptr));
        end
    endtask

    task automatic test_timeout;
        res_t r;
        do_reset;
        req = oh(2); req_write = '0;
        run_one(0, 0, 1, '0, 60, r);
`ifdef SDSCHED_TIMEOUT_EN
        checks++;
        if (r.done_v !== oh(2) || !r.err || r.done_from_g != TO + 1 || !r.once) begin
            errors++; $display("FAIL t6_timeout got done %b err %0d at %0d once %0d want %b 1 %0d 1",
                               r.done_v, r.err, r.done_from_g, r.once, oh(2), TO + 1);
        end
`else
        checks++;
        if (r.done_from_g != -1 || busy !== 1'b1 || error !== 1'b0 || grant !== oh(2)) begin
            errors++; $display("FAIL t6_no_timeout got done_at %0d busy %b err %b grant %b want -1 1 0 %b",
                               r.done_from_g, busy, error, grant, oh(2));
        end
`endif
    endtask

    task automatic test_random;
        res_t r;
        logic [0:3] rq;
        int d, exp_u, exp_lat;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            rq = 4'($urandom_range(1, 15));
            req = rq; req_write = 4'($urandom_range(0, 15));
            d = $urandom_range(0, 4);
            exp_u = pick(rq, m_ptr);
            exp_lat = d + 1 > 2 ? d + 1 : 2;
            run_one(d, 1, 0, 4'($urandom_range(0, 15)), 300, r);
            checks++;
            if (r.u != exp_u || r.lat_cmd != exp_lat || !r.cmd_ok || r.ncmd != 1 || !r.done_ok
                || r.done_gap != 1 || !r.once || !r.stable || r.err) begin
                errors++; $display("FAIL rand_%0d got unit %0d lat %0d cmd %0d n %0d done %0d gap %0d once %0d stable %0d err %0d want unit %0d lat %0d",
                                   i, r.u, r.lat_cmd, r.cmd_ok, r.ncmd, r.done_ok, r.done_gap, r.once,
                                   r.stable, r.err, exp_u, exp_lat);
            end
            m_ptr = (exp_u + 1) % 4;
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_round_robin;
        test_write_wait;
        test_reset_mid;
        test_req_change;
        test_timeout;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
